// File: rtl/bin_bcd_seq_ctrl_if.sv
// Handshake bundle between the ALU result path and the binary-to-BCD converter.
// The master side issues start plus operand; the slave side (converter) returns status and the result.
interface bin_bcd_seq_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic                  signed_mode;
    logic [WIDTH-1:0]      num_bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;

    modport master (
        output start, signed_mode, num_bin,
        input  busy, done, bcd_out, neg
    );

    modport slave (
        input  start, signed_mode, num_bin,
        output busy, done, bcd_out, neg
    );
endinterface

// File: rtl/bin_bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-add-3 iteration per clock.
// Signed operands are converted as a magnitude, and the sign is reported separately on neg.
module bin_bcd_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    bin_bcd_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      bin_reg;
    logic [4*DIGITS-1:0]   bcd_acc;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [CW-1:0]         cnt;
    logic                  neg_next;
    logic [WIDTH-1:0]      mag_in;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_out_q;
    logic                  neg_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CONV;
            CONV:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The most-negative value negates to 2^(WIDTH-1) as unsigned, which is the correct magnitude.
    always_comb begin
        mag_in = bus.num_bin;
        if (bus.signed_mode && bus.num_bin[WIDTH-1])
            mag_in = ~bus.num_bin + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg   <= '0;
            bcd_acc   <= '0;
            cnt       <= '0;
            neg_next  <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_reg  <= mag_in;
                        neg_next <= bus.signed_mode & bus.num_bin[WIDTH-1];
                        bcd_acc  <= '0;
                        cnt      <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    bcd_acc <= {bcd_adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
                    bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                end
                DONE: begin
                    bcd_out_q <= bcd_acc;
                    neg_q     <= neg_next;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_out_q;
    assign bus.neg     = neg_q;
endmodule

// File: tb/tb_bin_bcd_seq_ctrl.sv
// Self-checking bench for bin_bcd_seq_ctrl: fixed vectors, busy-start and reset corner cases,
// then randomised operands against an arithmetic decimal-digit reference model.
module tb_bin_bcd_seq_ctrl;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    typedef struct {
        logic        sm;
        logic [15:0] val;
        logic [19:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [19:0] last_bcd;
    logic        last_neg;

    always #5 clk = ~clk;

    bin_bcd_seq_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] refModel(input logic sm, input logic [15:0] val);
        int          mag;
        logic [19:0] b;
        mag = (sm && val[15]) ? (65536 - int'(val)) : int'(val);
        b = '0;
        for (int d = 0; d < DIGITS; d++) begin
            b[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {sm & val[15], b};
    endfunction

    // Called at a falling edge in IDLE; returns at the falling edge of the cycle after done.
    task automatic applyStimulus(input logic sm, input logic [15:0] val,
                                 input int inj_a, input int inj_b,
                                 output int lat, output int busy_cycles, output logic held,
                                 output logic [19:0] got_bcd, output logic got_neg,
                                 output logic done_after);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.num_bin     = val;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.signed_mode = 1'($urandom);
        bus.num_bin     = 16'($urandom);
        lat = 0;
        busy_cycles = 0;
        held = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.bcd_out !== last_bcd || bus.neg !== last_neg) held = 1'b0;
            bus.start = (lat == inj_a || lat == inj_b);
            if (bus.start) begin
                bus.num_bin     = 16'($urandom);
                bus.signed_mode = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        got_bcd   = bus.bcd_out;
        got_neg   = bus.neg;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic runAndCheck(input string tag, input logic sm, input logic [15:0] val,
                               input logic [19:0] exp_bcd, input logic exp_neg,
                               input int inj_a, input int inj_b, input bit full);
        int          lat, busy_cycles;
        logic        held, got_neg, done_after;
        logic [19:0] got_bcd;
        applyStimulus(sm, val, inj_a, inj_b, lat, busy_cycles, held, got_bcd, got_neg, done_after);
        checkOutput({tag, " bcd"}, 32'(got_bcd), 32'(exp_bcd));
        checkOutput({tag, " neg"}, 32'(got_neg), 32'(exp_neg));
        checkOutput({tag, " held"}, 32'(held), 32'd1);
        checkOutput({tag, " done width"}, 32'(done_after), 32'd0);
        if (full) begin
            checkOutput({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
            checkOutput({tag, " busy cycles"}, 32'(busy_cycles), 32'(WIDTH + 1));
        end
        last_bcd = exp_bcd;
        last_neg = exp_neg;
    endtask

    task automatic checkNoDone(input string tag, input int cycles);
        int dones = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checkOutput({tag, " spurious done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        vec_t        vecs[10];
        logic [20:0] r;
        logic [15:0] v;
        logic        sm;

        vecs[0] = '{1'b0, 16'h0000, 20'h00000, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 20'h65535, 1'b0};
        vecs[2] = '{1'b0, 16'h270F, 20'h09999, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF, 20'h00001, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 20'h32768, 1'b1};
        vecs[5] = '{1'b1, 16'h7FFF, 20'h32767, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 20'h32768, 1'b0};
        vecs[7] = '{1'b0, 16'h1234, 20'h04660, 1'b0};
        vecs[8] = '{1'b1, 16'hFC18, 20'h01000, 1'b1};
        vecs[9] = '{1'b0, 16'h0001, 20'h00001, 1'b0};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.num_bin     = '0;
        last_bcd        = '0;
        last_neg        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("reset neg", 32'(bus.neg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            runAndCheck($sformatf("vec%0d", i), vecs[i].sm, vecs[i].val,
                        vecs[i].exp_bcd, vecs[i].exp_neg, -1, -1, 1'b1);

        // Starts injected mid-conversion must be ignored; the follow-up start right after done is accepted.
        runAndCheck("busy start", 1'b0, 16'hFFFF, 20'h65535, 1'b0, 3, 10, 1'b1);
        runAndCheck("back to back", 1'b1, 16'hFFFE, 20'h00002, 1'b1, -1, -1, 1'b1);
        checkNoDone("after back to back", WIDTH + 4);

        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.num_bin     = 16'hABCD;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("abort neg", 32'(bus.neg), 32'd0);
        rst = 1'b0;
        last_bcd = '0;
        last_neg = 1'b0;
        checkNoDone("after abort", WIDTH + 4);
        runAndCheck("post abort", 1'b0, 16'h1234, 20'h04660, 1'b0, -1, -1, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       v = 16'h8000;
                1:       v = 16'hFFFF;
                2:       v = 16'h0000;
                default: v = 16'($urandom);
            endcase
            r = refModel(sm, v);
            if ($urandom_range(0, 3) == 0)
                runAndCheck("rand", sm, v, r[19:0], r[20],
                            $urandom_range(0, WIDTH - 1), $urandom_range(0, WIDTH - 1), 1'b1);
            else
                runAndCheck("rand", sm, v, r[19:0], r[20], -1, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
